// File: rtl/timer_set_ctrl.sv
// Front-panel edit controller for the MM:SS timer value.
// Captures the running time, edits one BCD digit at a time, commits with a load strobe.
module timer_set_ctrl #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cur_time,
    input  logic        btn_set,
    input  logic        btn_next,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        btn_ok,
    output logic [15:0] set_value,
    output logic        mux_sel,
    output logic        load,
    output logic [1:0]  digit_sel,
    output logic        blink
);

    localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state, state_n;

    logic [4:0] btn_q;
    logic e_set, e_next, e_inc, e_dec, e_ok;

    logic [CW-1:0]   cnt;
    logic [3:0][3:0] dv;
    logic [3:0]      dig;
    logic [3:0]      top;
    logic [15:0]     val_n;

    // Out-of-range digits become 0 so editing always starts from valid BCD
    function automatic logic [15:0] clean(input logic [15:0] v);
        logic [15:0] r;
        r[15:12] = (v[15:12] > 4'd5) ? 4'd0 : v[15:12];
        r[11:8]  = (v[11:8]  > 4'd9) ? 4'd0 : v[11:8];
        r[7:4]   = (v[7:4]   > 4'd5) ? 4'd0 : v[7:4];
        r[3:0]   = (v[3:0]   > 4'd9) ? 4'd0 : v[3:0];
        return r;
    endfunction

    // Button history; tracks live levels during reset so held buttons do not act
    always_ff @(posedge clk) begin
        btn_q <= {btn_set, btn_next, btn_inc, btn_dec, btn_ok};
    end

    assign e_set  = btn_set  & ~btn_q[4];
    assign e_next = btn_next & ~btn_q[3];
    assign e_inc  = btn_inc  & ~btn_q[2];
    assign e_dec  = btn_dec  & ~btn_q[1];
    assign e_ok   = btn_ok   & ~btn_q[0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic: set beats ok inside EDIT
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (e_set) state_n = EDIT;
            EDIT: begin
                if (e_set)     state_n = IDLE;
                else if (e_ok) state_n = COMMIT;
            end
            COMMIT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs decoded from the state register only
    always_comb begin
        mux_sel = (state == EDIT) || (state == COMMIT);
        load    = (state == COMMIT);
    end

    // Selected-digit inc/dec with per-digit wrap; inc and dec together cancel
    always_comb begin
        dv  = set_value;
        dig = dv[digit_sel];
        top = digit_sel[0] ? 4'd5 : 4'd9;
        if (e_inc && !e_dec) begin
            dv[digit_sel] = (dig >= top) ? 4'd0 : dig + 4'd1;
        end else if (e_dec && !e_inc) begin
            dv[digit_sel] = (dig == 4'd0 || dig > top) ? top : dig - 4'd1;
        end
        val_n = dv;
    end

    // Edit datapath: captured value, digit pointer and blink phase
    always_ff @(posedge clk) begin
        if (rst) begin
            set_value <= 16'h0000;
            digit_sel <= 2'd3;
            blink     <= 1'b0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    blink <= 1'b0;
                    cnt   <= '0;
                    if (e_set) begin
                        set_value <= clean(cur_time);
                        digit_sel <= 2'd3;
                        blink     <= 1'b1;
                    end
                end
                EDIT: begin
                    if (e_set || e_ok) begin
                        blink <= 1'b0;
                        cnt   <= '0;
                    end else if (e_next) begin
                        digit_sel <= digit_sel - 2'd1;
                        blink     <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        set_value <= val_n;
                        if (cnt == CNT_TOP) begin
                            cnt   <= '0;
                            blink <= ~blink;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    blink <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
